// File: rtl/uart_cmd_parser.sv
// ============================================================================
// Module   : uart_cmd_parser
// Purpose  : Assembles 7-byte UART command frames, checks the XOR checksum,
//            updates waveform control registers and queues an ACK/NAK reply.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  DEF_SIGNAL     = 8'd0,
    parameter logic [31:0] DEF_ADDER      = 32'd4295,
    parameter logic [31:0] DEF_AMPLITUDE  = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  signalNumber,
    output logic [31:0] adder,
    output logic [31:0] amplitude,
    output logic        cfg_update,
    output logic        frame_error
);

    localparam logic [2:0]  c_IDLE     = 3'd0;
    localparam logic [2:0]  c_GET_CMD  = 3'd1;
    localparam logic [2:0]  c_GET_DATA = 3'd2;
    localparam logic [2:0]  c_GET_CHK  = 3'd3;
    localparam logic [2:0]  c_RESP     = 3'd4;
    localparam logic [16:0] c_TO_LAST  = 17'(TIMEOUT_CYCLES - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [7:0]  r_cmd;
    logic [31:0] r_data;
    logic [1:0]  r_idx;
    logic [7:0]  r_xor;
    logic [16:0] r_idle;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic [7:0]  r_signal;
    logic [31:0] r_adder;
    logic [31:0] r_amplitude;
    logic        r_cfg_update;
    logic        r_frame_error;

    logic        w_in_frame;
    logic        w_timeout;
    logic        w_chk_strobe;
    logic        w_known;
    logic        w_good;
    logic        w_bad;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:     if (rx_valid && rx_data == SYNC_BYTE) w_state_next = c_GET_CMD;
            c_GET_CMD:  if (w_timeout) w_state_next = c_IDLE;
                        else if (rx_valid) w_state_next = c_GET_DATA;
            c_GET_DATA: if (w_timeout) w_state_next = c_IDLE;
                        else if (rx_valid && r_idx == 2'd3) w_state_next = c_GET_CHK;
            c_GET_CHK:  if (w_timeout) w_state_next = c_IDLE;
                        else if (rx_valid) w_state_next = c_RESP;
            c_RESP:     if (r_tx_valid && tx_ready) w_state_next = c_IDLE;
            default:    w_state_next = c_IDLE;
        endcase
    end

    // Frame decode feeding the registered outputs
    always_comb begin
        w_in_frame   = (r_state == c_GET_CMD) || (r_state == c_GET_DATA) ||
                       (r_state == c_GET_CHK);
        w_timeout    = w_in_frame && !rx_valid && (r_idle == c_TO_LAST);
        w_chk_strobe = (r_state == c_GET_CHK) && rx_valid;
        w_known      = (r_cmd == 8'h01) || (r_cmd == 8'h02) || (r_cmd == 8'h03);
        w_good       = w_chk_strobe && (rx_data == r_xor) && w_known;
        w_bad        = w_chk_strobe && !((rx_data == r_xor) && w_known);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd         <= 8'd0;
            r_data        <= 32'd0;
            r_idx         <= 2'd0;
            r_xor         <= 8'd0;
            r_idle        <= 17'd0;
            r_tx_data     <= 8'd0;
            r_tx_valid    <= 1'b0;
            r_signal      <= DEF_SIGNAL;
            r_adder       <= DEF_ADDER;
            r_amplitude   <= DEF_AMPLITUDE;
            r_cfg_update  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_cfg_update  <= 1'b0;
            r_frame_error <= w_bad || w_timeout;

            if (!w_in_frame || rx_valid || w_timeout) r_idle <= 17'd0;
            else                                      r_idle <= r_idle + 17'd1;

            case (r_state)
                c_IDLE: if (rx_valid && rx_data == SYNC_BYTE) r_xor <= 8'd0;
                c_GET_CMD: if (rx_valid) begin
                    r_cmd <= rx_data;
                    r_xor <= r_xor ^ rx_data;
                    r_idx <= 2'd0;
                end
                c_GET_DATA: if (rx_valid) begin
                    r_data <= {r_data[23:0], rx_data};
                    r_xor  <= r_xor ^ rx_data;
                    if (r_idx != 2'd3) r_idx <= r_idx + 2'd1;
                end
                c_GET_CHK: if (rx_valid) begin
                    r_tx_valid <= 1'b1;
                    r_tx_data  <= w_good ? ACK_BYTE : NAK_BYTE;
                    if (w_good) begin
                        r_cfg_update <= 1'b1;
                        case (r_cmd)
                            8'h01:   r_signal    <= r_data[7:0];
                            8'h02:   r_adder     <= r_data;
                            default: r_amplitude <= r_data;
                        endcase
                    end
                end
                c_RESP: if (r_tx_valid && tx_ready) r_tx_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign tx_data      = r_tx_data;
    assign tx_valid     = r_tx_valid;
    assign signalNumber = r_signal;
    assign adder        = r_adder;
    assign amplitude    = r_amplitude;
    assign cfg_update   = r_cfg_update;
    assign frame_error  = r_frame_error;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
// ============================================================================
// Module   : tb_uart_cmd_parser
// Purpose  : Self-checking bench for uart_cmd_parser (directed table + random).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_cmd_parser;

    localparam int c_TO = 300;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [7:0]  signalNumber;
    logic [31:0] adder;
    logic [31:0] amplitude;
    logic        cfg_update;
    logic        frame_error;

    int total = 0;
    int bad   = 0;

    logic [7:0]  m_sig;
    logic [31:0] m_add;
    logic [31:0] m_amp;

    uart_cmd_parser #(.TIMEOUT_CYCLES(c_TO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .signalNumber(signalNumber), .adder(adder), .amplitude(amplitude),
        .cfg_update(cfg_update), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [55:0] frame;
        logic [7:0]  tx;
        logic        cfg;
        logic        err;
        logic [7:0]  sig;
        logic [31:0] add;
        logic [31:0] amp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [55:0] f, input int max_gap);
        for (int i = 6; i >= 0; i--) send_byte(f[i*8 +: 8], $urandom_range(0, max_gap));
    endtask

    // Called at the first falling edge after the CHK byte was sampled
    task automatic check_reply(input string name, input logic [7:0] exp_tx, input logic exp_cfg,
                               input logic exp_err, input int ready_delay);
        chk({name, " tx_valid"}, 32'(tx_valid), 32'd1);
        chk({name, " tx_data"}, 32'(tx_data), 32'(exp_tx));
        chk({name, " cfg_update"}, 32'(cfg_update), 32'(exp_cfg));
        chk({name, " frame_error"}, 32'(frame_error), 32'(exp_err));
        for (int i = 0; i < ready_delay; i++) begin
            @(negedge clk);
            chk({name, " held"}, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, exp_tx});
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk({name, " tx_valid drop"}, 32'(tx_valid), 32'd0);
        chk({name, " pulses clear"}, {30'd0, cfg_update, frame_error}, 32'd0);
    endtask

    task automatic check_regs(input string name);
        chk({name, " signalNumber"}, 32'(signalNumber), 32'(m_sig));
        chk({name, " adder"}, adder, m_add);
        chk({name, " amplitude"}, amplitude, m_amp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_sig = 8'd0;
        m_add = 32'd4295;
        m_amp = 32'hFFFFFFFF;
    endtask

    vec_t vecs [8];

    initial begin
        int k;
        int err_cycles;
        int tx_seen;
        vecs[0] = '{56'hA5_02_00_10_00_00_12, 8'h06, 1'b1, 1'b0, 8'h00, 32'h00100000, 32'hFFFFFFFF};
        vecs[1] = '{56'hA5_03_12_34_56_78_00, 8'h15, 1'b0, 1'b1, 8'h00, 32'h00100000, 32'hFFFFFFFF};
        vecs[2] = '{56'hA5_01_00_00_00_02_03, 8'h06, 1'b1, 1'b0, 8'h02, 32'h00100000, 32'hFFFFFFFF};
        vecs[3] = '{56'hA5_03_12_34_56_78_0B, 8'h06, 1'b1, 1'b0, 8'h02, 32'h00100000, 32'h12345678};
        vecs[4] = '{56'hA5_07_00_00_00_00_07, 8'h15, 1'b0, 1'b1, 8'h02, 32'h00100000, 32'h12345678};
        vecs[5] = '{56'hA5_01_AA_BB_CC_05_D9, 8'h06, 1'b1, 1'b0, 8'h05, 32'h00100000, 32'h12345678};
        vecs[6] = '{56'hA5_02_A5_A5_A5_A5_02, 8'h06, 1'b1, 1'b0, 8'h05, 32'hA5A5A5A5, 32'h12345678};
        vecs[7] = '{56'hA5_00_00_00_00_00_FF, 8'h15, 1'b0, 1'b1, 8'h05, 32'hA5A5A5A5, 32'h12345678};

        @(negedge clk);
        do_reset();
        check_regs("reset");
        chk("reset tx", {22'd0, tx_valid, cfg_update, tx_data}, 32'd0);
        chk("reset frame_error", 32'(frame_error), 32'd0);

        // Directed frames, state accumulates across the table
        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].frame, 0);
            check_reply($sformatf("vec%0d", v), vecs[v].tx, vecs[v].cfg, vecs[v].err, v % 3);
            m_sig = vecs[v].sig; m_add = vecs[v].add; m_amp = vecs[v].amp;
            check_regs($sformatf("vec%0d", v));
        end

        // Timeout: frame missing its CHK byte
        for (int i = 6; i >= 1; i--) send_byte(vecs[2].frame[i*8 +: 8], 0);
        k = 0; err_cycles = 0; tx_seen = 0;
        for (int i = 1; i <= c_TO + 20; i++) begin
            @(negedge clk);
            if (frame_error) begin
                err_cycles++;
                if (k == 0) k = i;
            end
            if (tx_valid) tx_seen++;
        end
        chk("timeout cycle", 32'(k), 32'(c_TO));
        chk("timeout pulse width", 32'(err_cycles), 32'd1);
        chk("timeout no reply", 32'(tx_seen), 32'd0);
        check_regs("timeout");
        send_frame(vecs[2].frame, 0);
        check_reply("after timeout", 8'h06, 1'b1, 1'b0, 0);
        m_sig = 8'h02;
        check_regs("after timeout");

        // Back-pressured reply with extra bytes arriving during RESP
        send_byte(8'h33, 0);
        send_frame(56'hA5_01_00_00_00_01_00, 0);
        m_sig = 8'h01;
        tx_seen = 0;
        for (int i = 0; i < 20; i++) begin
            rx_valid = (i % 4 == 1);
            rx_data  = (i % 8 == 1) ? 8'hA5 : 8'($urandom);
            @(negedge clk);
            if (tx_valid === 1'b1 && tx_data === 8'h06) tx_seen++;
        end
        rx_valid = 1'b0;
        chk("resp hold cycles", 32'(tx_seen), 32'd20);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (tx_valid) tx_seen++;
        end
        tx_ready = 1'b0;
        chk("resp single reply", 32'(tx_seen), 32'd0);
        check_regs("resp");

        // Reset during D2 of an adder frame
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h11, 0);
        rx_data = 8'h22; rx_valid = 1'b1; reset = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_sig = 8'd0; m_add = 32'd4295; m_amp = 32'hFFFFFFFF;
        check_regs("midframe reset");
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h31, 0);
        tx_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx_valid || cfg_update) tx_seen++;
        end
        chk("midframe reset no reply", 32'(tx_seen), 32'd0);
        send_frame(56'hA5_02_00_00_00_2A_28, 0);
        check_reply("post reset frame", 8'h06, 1'b1, 1'b0, 1);
        m_add = 32'h0000002A;
        check_regs("post reset frame");

        // Randomized frames against the frame-level model
        do_reset();
        for (int f = 0; f < 40; f++) begin
            logic [7:0]  cmd;
            logic [31:0] d;
            logic [7:0]  cs;
            logic        good;
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                logic [7:0] junk;
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h00;
                send_byte(junk, $urandom_range(0, 2));
            end
            cmd = 8'($urandom_range(0, 4));
            d   = $urandom;
            cs  = cmd ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            good = (cs == (cmd ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0])) &&
                   (cmd >= 8'd1) && (cmd <= 8'd3);
            send_frame({8'hA5, cmd, d, cs}, 3);
            check_reply($sformatf("rand%0d", f), good ? 8'h06 : 8'h15, good, !good,
                        $urandom_range(0, 3));
            if (good) begin
                if (cmd == 8'd1)      m_sig = d[7:0];
                else if (cmd == 8'd2) m_add = d;
                else                  m_amp = d;
            end
            check_regs($sformatf("rand%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
